gnt_pulse_arbiter: RTL and testbench
====================================

// Module: gnt_pulse_arbiter
// PURPOSE
//  Grant-side sender for the fixed-width grant protocol consumed by the dut.
//  Round-robin arbiter over NUM_REQ requesters; issues a registered,
//  one-hot grant pulse of exactly GNT_CYCLES clocks, followed by at least
//  GAP_CYCLES low clocks. Includes a starvation watchdog that flags a
//  requester left pending too long (deadlock debug aid).
// PARAMETERS
//  NUM_REQ     4    number of requesters (>=2)
//  GNT_CYCLES  8    exact grant pulse width in clocks (>=1)
//  GAP_CYCLES  1    minimum low clocks between pulses (>=1)
//  TIMEOUT     64   pending-request clocks before starve flag (>GNT_CYCLES+GAP_CYCLES)
// PORTS
//  clk        in   1          clock, all logic on posedge
//  reset      in   1          asynchronous, active-high reset
//  req        in   NUM_REQ    level request per requester
//  gnt        out  NUM_REQ    one-hot grant, driven straight from flops
//  gnt_id     out  $clog2(NUM_REQ)  index of current/last granted requester
//  busy       out  1          high in GRANT or GAP state
//  starve     out  NUM_REQ    sticky per-requester watchdog flag
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-pulse): gnt=0, gnt_id=0, busy=0,
//   starve=0, state=IDLE, rr pointer=0, all counters=0. Pulse aborts at once.
//  FSM states: IDLE, GRANT, GAP.
//   IDLE: on edge with req!=0, pick winner = first set bit at or after rr
//    pointer (wrapping); go GRANT; gnt[winner] high from this edge.
//    Latency req->gnt = 1 clock.
//   GRANT: gnt held constant for exactly GNT_CYCLES clocks (cnt 0..GNT_CYCLES-1),
//    then go GAP, gnt=0. Requester dropping req mid-pulse does NOT shorten
//    the pulse; new reqs do not preempt.
//   GAP: gnt=0 for GAP_CYCLES clocks; then if req!=0 go straight to GRANT
//    (arbitrate on that edge) else IDLE. Back-to-back pulses therefore
//    separated by exactly GAP_CYCLES low clocks.
//  rr pointer <= winner+1 (mod NUM_REQ) when a grant is issued; winner has
//   lowest priority in next arbitration.
//  gnt_id updates with gnt and holds its value through GAP/IDLE.
//  Invariants: gnt one-hot or zero; every rising edge of gnt[i] followed by
//   exactly GNT_CYCLES-1 further high clocks then a low clock.
//  Watchdog: per requester wait counter; increments each clock req[i]=1 and
//   gnt[i]=0, clears when req[i]=0 or gnt[i]=1; saturates at TIMEOUT.
//   starve[i] sets on the edge the counter reaches TIMEOUT; sticky until reset.
//   Counter width $clog2(TIMEOUT+1), no wrap.
//  Simultaneous reqs: single winner per arbitration, rest keep waiting.
// TESTING
//  1 reset, req=0 for 20 clks -> gnt=0, busy=0, starve=0 throughout.
//  2 req=4'b0010 single clk -> gnt=4'b0010 high exactly 8 clks starting 1
//    clk later, gnt_id=1, then low; pulse full width though req dropped.
//  3 req=4'b1111 held -> grants 0,1,2,3,0... each 8 high, 1 low between;
//    never two bits high; no starve within 200 clks.
//  4 reset asserted at 4th grant clock -> gnt=0 same cycle (async); after
//    release with req=4'b0100 -> fresh 8-clk pulse to requester 2.
//  5 TIMEOUT=16 build, force arbiter held via req=4'b0001 with stuck FSM
//    (GNT_CYCLES=32) while req[3]=1 -> starve[3] rises after 16 waiting
//    clks, stays 1 after req[3] later granted.
//  6 SVA bind: $rose(gnt[i]) |-> gnt[i][*GNT_CYCLES] ##1 !gnt[i] and
//    $onehot0(gnt) hold under random req for 10k clks.

Source files
------------

// File: rtl/gnt_pulse_arbiter.sv
// Round-robin grant-pulse sender: one-hot registered grant of exactly GNT_CYCLES clocks,
// at least GAP_CYCLES low clocks between pulses, plus a sticky per-requester starvation flag.
module gnt_pulse_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GNT_CYCLES = 8,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         starve,
  output logic [1:0]                 dbg_state
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CMAX = (GNT_CYCLES > GAP_CYCLES) ? GNT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int WW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [IDW-1:0]     winner, winner_nxt;
  logic [IDW:0]       arb_sum;
  logic               arb_found;
  logic               grant_now;
  logic [WW-1:0]      wait_q [NUM_REQ];
  logic [WW-1:0]      wait_d [NUM_REQ];
  logic [NUM_REQ-1:0] starve_q, starve_d;

  // Scan requesters starting at the rr pointer, wrapping; first set bit wins.
  always_comb begin
    winner    = '0;
    arb_found = 1'b0;
    arb_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (arb_sum >= (IDW+1)'(NUM_REQ)) arb_sum = arb_sum - (IDW+1)'(NUM_REQ);
      if (!arb_found && req[arb_sum[IDW-1:0]]) begin
        arb_found = 1'b1;
        winner    = arb_sum[IDW-1:0];
      end
    end
    winner_nxt = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    rr_d      = rr_q;
    grant_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) grant_now = 1'b1;
      end
      S_GRANT: begin
        if (cnt_q == CW'(GNT_CYCLES - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
          gnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          if (|req) grant_now = 1'b1;
          else      state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
    // A new pulse starts on the same edge the arbitration happens.
    if (grant_now) begin
      state_d  = S_GRANT;
      cnt_d    = '0;
      gnt_d    = NUM_REQ'(1) << winner;
      gnt_id_d = winner;
      rr_d     = winner_nxt;
    end
  end

  // Watchdog counts clocks spent requesting without holding the grant.
  always_comb begin
    starve_d = starve_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_d[i] = '0;
      if (req[i] && !gnt_q[i]) begin
        wait_d[i] = (wait_q[i] == WW'(TIMEOUT)) ? wait_q[i] : wait_q[i] + WW'(1);
      end
      if (wait_d[i] == WW'(TIMEOUT)) starve_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      rr_q     <= '0;
      starve_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = (state_q != S_IDLE);
  assign starve    = starve_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gnt_pulse_arbiter.sv
// Bench for gnt_pulse_arbiter: default build checked cycle-by-cycle against a timeline model,
// plus a TIMEOUT=16 / GNT_CYCLES=32 build for the starvation watchdog.
module tb_gnt_pulse_arbiter;

  localparam int N    = 4;
  localparam int G    = 8;
  localparam int GAP  = 1;
  localparam int TO   = 64;
  localparam int G_B  = 32;
  localparam int TO_B = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [N-1:0] req_a, gnt_a, starve_a;
  logic [1:0]   gid_a, st_a;
  logic         busy_a;
  logic [N-1:0] req_b, gnt_b, starve_b;
  logic [1:0]   gid_b, st_b;
  logic         busy_b;

  gnt_pulse_arbiter #(.NUM_REQ(N), .GNT_CYCLES(G), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .gnt(gnt_a), .gnt_id(gid_a),
    .busy(busy_a), .starve(starve_a), .dbg_state(st_a)
  );

  gnt_pulse_arbiter #(.NUM_REQ(N), .GNT_CYCLES(G_B), .GAP_CYCLES(GAP), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .gnt(gnt_b), .gnt_id(gid_b),
    .busy(busy_b), .starve(starve_b), .dbg_state(st_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model (timeline of pulses) ----------------
  // A grant issued at edge t keeps gnt high after edges t..t+G-1, busy through
  // t+G+GAP-1, and the next arbitration is allowed from edge t+G+GAP.
  int           m_edge, m_next_arb, m_start, m_owner, m_ptr;
  int           m_wait [N];
  logic [N-1:0] m_gnt, m_starve;
  logic [1:0]   m_gid;
  logic         m_busy;
  logic [1:0]   exp_q [$];

  function void model_reset();
    m_edge = 0; m_next_arb = 0; m_start = -1000; m_owner = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_gnt = '0; m_starve = '0; m_gid = '0; m_busy = 1'b0;
  endfunction

  function void model_step(input logic [N-1:0] r);
    logic [N-1:0] prev;
    logic [1:0]   idx;
    bit           found;
    int           e;
    prev = m_gnt;
    for (int i = 0; i < N; i++) begin
      if (r[i] && !prev[i]) begin
        if (m_wait[i] < TO) m_wait[i]++;
      end else begin
        m_wait[i] = 0;
      end
      if (m_wait[i] == TO) m_starve[i] = 1'b1;
    end
    e = m_edge;
    m_edge++;
    if (e >= m_next_arb && r != '0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = 2'((m_ptr + k) % N);
        if (!found && r[idx]) begin
          found = 1; m_owner = int'(idx);
        end
      end
      m_start    = e;
      m_ptr      = (m_owner + 1) % N;
      m_next_arb = e + G + GAP;
      exp_q.push_back(2'(m_owner));
    end
    m_gnt  = (m_start >= 0 && e - m_start < G) ? (4'(1) << m_owner) : 4'b0;
    m_busy = (m_start >= 0 && e - m_start < G + GAP);
    m_gid  = 2'(m_owner);
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic [N-1:0] r);
    req_a = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_a = '0; req_b = '0;
    @(negedge clk);
    n_cmp++;
    if ({gnt_a, gid_a, busy_a, starve_a, gnt_b, starve_b} !== 15'b0) begin
      n_err++;
      $display("FAIL reset_state gnt=%b id=%0d busy=%b starve=%b gnt_b=%b starve_b=%b, want all 0",
               gnt_a, gid_a, busy_a, starve_a, gnt_b, starve_b);
    end
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    for (int c = 0; c < 20; c++) begin
      drive_cycle('0);
      n_cmp++;
      if ({gnt_a, gid_a, busy_a, starve_a} !== {m_gnt, m_gid, m_busy, m_starve}) begin
        n_err++;
        $display("FAIL idle c=%0d gnt=%b/%b id=%0d/%0d busy=%b/%b starve=%b/%b", c,
                 gnt_a, m_gnt, gid_a, m_gid, busy_a, m_busy, starve_a, m_starve);
      end
    end
  endtask

  task automatic test_single_pulse();
    int hi = 0;
    for (int c = 0; c < 14; c++) begin
      drive_cycle((c == 0) ? 4'b0010 : 4'b0000);
      hi += int'(gnt_a[1]);
      n_cmp++;
      if ({gnt_a, gid_a, busy_a, starve_a} !== {m_gnt, m_gid, m_busy, m_starve}) begin
        n_err++;
        $display("FAIL single c=%0d gnt=%b/%b id=%0d/%0d busy=%b/%b starve=%b/%b", c,
                 gnt_a, m_gnt, gid_a, m_gid, busy_a, m_busy, starve_a, m_starve);
      end
    end
    n_cmp++;
    if (hi !== G) begin
      n_err++;
      $display("FAIL single_width got %0d high clocks want %0d", hi, G);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] prev_g = '0;
    logic [1:0]   want;
    exp_q.delete();
    for (int c = 0; c < 200; c++) begin
      drive_cycle(4'b1111);
      n_cmp++;
      if ({gnt_a, gid_a, busy_a, starve_a} !== {m_gnt, m_gid, m_busy, m_starve} || !$onehot0(gnt_a)) begin
        n_err++;
        $display("FAIL b2b c=%0d gnt=%b/%b id=%0d/%0d busy=%b/%b starve=%b/%b", c,
                 gnt_a, m_gnt, gid_a, m_gid, busy_a, m_busy, starve_a, m_starve);
      end
      if (gnt_a != '0 && prev_g == '0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_order c=%0d got id %0d want no grant", c, gid_a);
        end else begin
          want = exp_q.pop_front();
          if (gid_a !== want) begin
            n_err++;
            $display("FAIL b2b_order c=%0d got id %0d want %0d", c, gid_a, want);
          end
        end
      end
      prev_g = gnt_a;
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_missing got %0d unissued grants want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_pulse();
    int hi = 0;
    for (int c = 0; c < 12; c++) drive_cycle('0);
    for (int c = 0; c < 4; c++) begin
      drive_cycle((c == 0) ? 4'b1111 : 4'b0000);
      n_cmp++;
      if (gnt_a !== m_gnt) begin
        n_err++;
        $display("FAIL pre_abort c=%0d gnt=%b want %b", c, gnt_a, m_gnt);
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({gnt_a, gid_a, busy_a} !== 7'b0) begin
      n_err++;
      $display("FAIL async_abort gnt=%b id=%0d busy=%b want 0/0/0", gnt_a, gid_a, busy_a);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive_cycle((c == 0) ? 4'b0100 : 4'b0000);
      hi += int'(gnt_a[2]);
      n_cmp++;
      if ({gnt_a, gid_a, busy_a, starve_a} !== {m_gnt, m_gid, m_busy, m_starve}) begin
        n_err++;
        $display("FAIL post_reset c=%0d gnt=%b/%b id=%0d/%0d busy=%b/%b", c,
                 gnt_a, m_gnt, gid_a, m_gid, busy_a, m_busy);
      end
    end
    n_cmp++;
    if (hi !== G) begin
      n_err++;
      $display("FAIL post_reset_width got %0d high clocks want %0d", hi, G);
    end
    exp_q.delete();
  endtask

  // Requester 0 holds the long grant while requester 3 waits; starve[3] must
  // rise after TO_B waiting clocks and survive requester 3 being granted later.
  task automatic test_starve();
    logic [N-1:0] want_g, want_s;
    req_b = 4'b1001;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) req_b = 4'b1000;
      want_g = (k <= G_B) ? 4'b0001 : (k == G_B + 1) ? 4'b0000 : 4'b1000;
      want_s = (k >= TO_B) ? 4'b1000 : 4'b0000;
      n_cmp++;
      if (gnt_b !== want_g || starve_b !== want_s) begin
        n_err++;
        $display("FAIL starve k=%0d gnt=%b/%b starve=%b/%b", k, gnt_b, want_g, starve_b, want_s);
      end
    end
    req_b = '0;
    n_cmp++;
    if (gid_b !== 2'd3) begin
      n_err++;
      $display("FAIL starve_gid got %0d want 3", gid_b);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r = '0;
    exp_q.delete();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      drive_cycle(r);
      n_cmp++;
      if ({gnt_a, gid_a, busy_a, starve_a} !== {m_gnt, m_gid, m_busy, m_starve} || !$onehot0(gnt_a)) begin
        n_err++;
        $display("FAIL random c=%0d req=%b gnt=%b/%b id=%0d/%0d busy=%b/%b starve=%b/%b", c, r,
                 gnt_a, m_gnt, gid_a, m_gid, busy_a, m_busy, starve_a, m_starve);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_reset_mid_pulse();
    test_starve();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
